// File: rtl/ysyx_22040759_wbu.sv
// Writeback unit: formats load data, holds one result in a stage register, drives the GPR write port.
// Optional decode bypass of the in-flight result when YSYX_22040759_WB_BYPASS_EN is defined.
module ysyx_22040759_wbu #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_wen,
  input  logic             in_sel,
  input  logic [XLEN-1:0]  in_alu_res,
  input  logic [XLEN-1:0]  in_ld_data,
  input  logic [1:0]       in_ld_off,
  input  logic [2:0]       in_ld_funct3,
  input  logic             wb_stall,
  output logic             gpr_wen,
  output logic [4:0]       gpr_waddr,
  output logic [XLEN-1:0]  gpr_wdata,
  output logic             retire,
  output logic [CNT_W-1:0] instret
`ifdef YSYX_22040759_WB_BYPASS_EN
  ,
  output logic             byp_valid,
  output logic [4:0]       byp_rd,
  output logic [XLEN-1:0]  byp_data
`endif
);

  logic            st_valid;
  logic [4:0]      st_rd;
  logic            st_wen;
  logic [XLEN-1:0] st_data;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_fmt;
  logic [XLEN-1:0] wb_data;
  logic            accept;

  // Byte/half lane select from the address offset; half ignores off[0]
  always_comb begin
    ld_byte = 8'h00;
    case (in_ld_off)
      2'd0:    ld_byte = in_ld_data[7:0];
      2'd1:    ld_byte = in_ld_data[15:8];
      2'd2:    ld_byte = in_ld_data[23:16];
      default: ld_byte = in_ld_data[31:24];
    endcase
    ld_half = in_ld_off[1] ? in_ld_data[31:16] : in_ld_data[15:0];
  end

  // Reserved funct3 codes fall through to a full-word load
  always_comb begin
    ld_fmt = in_ld_data;
    case (in_ld_funct3)
      3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = XLEN'(ld_byte);
      3'b001:  ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = XLEN'(ld_half);
      default: ld_fmt = in_ld_data;
    endcase
    wb_data = in_sel ? ld_fmt : in_alu_res;
  end

  assign in_ready  = !st_valid || !wb_stall;
  assign accept    = in_valid && in_ready;
  assign retire    = st_valid && !wb_stall;
  assign gpr_wen   = st_valid && st_wen && (st_rd != 5'd0) && !wb_stall;
  assign gpr_waddr = st_rd;
  assign gpr_wdata = st_data;

`ifdef YSYX_22040759_WB_BYPASS_EN
  assign byp_valid = st_valid && st_wen && (st_rd != 5'd0);
  assign byp_rd    = st_rd;
  assign byp_data  = st_data;
`endif

  // Stage register: refill on accept, otherwise empty on retire
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_valid <= 1'b0;
      st_rd    <= 5'd0;
      st_wen   <= 1'b0;
      st_data  <= '0;
    end else if (accept) begin
      st_valid <= 1'b1;
      st_rd    <= in_rd;
      st_wen   <= in_rd_wen;
      st_data  <= wb_data;
    end else if (retire) begin
      st_valid <= 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_wbu.sv
// Scoreboard bench for ysyx_22040759_wbu: driver pushes expected writebacks, negedge monitor pops/compares.
// A second CNT_W=4 instance shares the stimulus to exercise counter wrap.
module tb_ysyx_22040759_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_rd_wen, in_sel, wb_stall;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_res, in_ld_data;
  logic [1:0]  in_ld_off;
  logic [2:0]  in_ld_funct3;

  logic        in_ready, gpr_wen, retire;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [63:0] instret;

  logic        s_in_ready, s_gpr_wen, s_retire;
  logic [4:0]  s_gpr_waddr;
  logic [31:0] s_gpr_wdata;
  logic [3:0]  s_instret;

`ifdef YSYX_22040759_WB_BYPASS_EN
  logic        byp_valid, s_byp_valid;
  logic [4:0]  byp_rd, s_byp_rd;
  logic [31:0] byp_data, s_byp_data;
`endif

  always #5 clk = ~clk;

  ysyx_22040759_wbu #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_sel(in_sel),
    .in_alu_res(in_alu_res), .in_ld_data(in_ld_data), .in_ld_off(in_ld_off),
    .in_ld_funct3(in_ld_funct3), .wb_stall(wb_stall),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .retire(retire), .instret(instret)
`ifdef YSYX_22040759_WB_BYPASS_EN
    , .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
`endif
  );

  ysyx_22040759_wbu #(.XLEN(32), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_sel(in_sel),
    .in_alu_res(in_alu_res), .in_ld_data(in_ld_data), .in_ld_off(in_ld_off),
    .in_ld_funct3(in_ld_funct3), .wb_stall(wb_stall),
    .gpr_wen(s_gpr_wen), .gpr_waddr(s_gpr_waddr), .gpr_wdata(s_gpr_wdata),
    .retire(s_retire), .instret(s_instret)
`ifdef YSYX_22040759_WB_BYPASS_EN
    , .byp_valid(s_byp_valid), .byp_rd(s_byp_rd), .byp_data(s_byp_data)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic        wen;   // expected write-enable (rd != 0 already folded in)
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [63:0] model_cnt = 64'd0;
  bit          mon_en = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference load formatting by shift/mask arithmetic; sign extension by subtracting 2^width
  function automatic logic [31:0] ref_result(input logic sel, input logic [31:0] alu,
                                             input logic [31:0] data, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] v;
    if (!sel) return alu;
    case (f3)
      3'd0, 3'd4: begin
        v = (data >> (32'(off) * 8)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (data >> (32'(off[1]) * 16)) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = data;
    endcase
    return v;
  endfunction

  // One cycle of stimulus; expectation pushed only if the handshake completes
  task automatic issue(input logic v, input logic [4:0] rd, input logic wen, input logic sel,
                       input logic [31:0] alu, input logic [31:0] data, input logic [1:0] off,
                       input logic [2:0] f3, input logic stall, input logic [31:0] exp_data);
    bit   acc;
    exp_t e;
    in_valid = v; in_rd = rd; in_rd_wen = wen; in_sel = sel; in_alu_res = alu;
    in_ld_data = data; in_ld_off = off; in_ld_funct3 = f3; wb_stall = stall;
    e.rd = rd; e.wen = wen && (rd != 5'd0); e.data = exp_data;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    if (acc) q.push_back(e);
    #1;
  endtask

  task automatic issue_rand();
    logic        v, wen, sel, st;
    logic [4:0]  rd;
    logic [31:0] alu, data;
    logic [1:0]  off;
    logic [2:0]  f3;
    v = ($urandom_range(0, 3) != 0); st = ($urandom_range(0, 3) == 0);
    rd = 5'($urandom); wen = 1'($urandom); sel = 1'($urandom);
    alu = $urandom; data = $urandom; off = 2'($urandom); f3 = 3'($urandom);
    issue(v, rd, wen, sel, alu, data, off, f3, st, ref_result(sel, alu, data, off, f3));
  endtask

  task automatic idle(input logic stall);
    issue(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 3'd0, stall, 32'd0);
  endtask

  // Monitor: stage occupancy is the scoreboard depth (at most one entry)
  always @(negedge clk) begin
    if (mon_en) begin
      bit   has;
      exp_t f;
      has = (q.size() > 0);
      if (has) f = q[0];
      check("in_ready", 64'(in_ready), 64'(!has || !wb_stall));
      check("retire", 64'(retire), 64'(has && !wb_stall));
      check("gpr_wen", 64'(gpr_wen), 64'(has && f.wen && !wb_stall));
      if (has) begin
        check("gpr_waddr", 64'(gpr_waddr), 64'(f.rd));
        check("gpr_wdata", 64'(gpr_wdata), 64'(f.data));
      end
`ifdef YSYX_22040759_WB_BYPASS_EN
      check("byp_valid", 64'(byp_valid), 64'(has && f.wen));
      if (has) check("byp_data", 64'(byp_data), 64'(f.data));
`endif
      check("instret", instret, model_cnt);
      check("instret_w4", 64'(s_instret), model_cnt % 64'd16);
      if (has && !wb_stall) begin
        void'(q.pop_front());
        model_cnt = model_cnt + 64'd1;
      end
    end
  end

  initial begin
    // Reset with random inputs applied
    rst = 1'b0;
    in_valid = 1'b1; in_rd = 5'($urandom) | 5'd1; in_rd_wen = 1'b1; in_sel = 1'($urandom);
    in_alu_res = $urandom; in_ld_data = $urandom; in_ld_off = 2'($urandom);
    in_ld_funct3 = 3'($urandom); wb_stall = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check("rst_gpr_wen", 64'(gpr_wen), 64'd0);
    check("rst_gpr_waddr", 64'(gpr_waddr), 64'd0);
    check("rst_gpr_wdata", 64'(gpr_wdata), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_instret", instret, 64'd0);
    in_valid = 1'b0; wb_stall = 1'b0;
    rst = 1'b1;
    mon_en = 1'b1;

    // ALU writeback
    issue(1'b1, 5'd5, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 2'd0, 3'd0, 1'b0, 32'hDEADBEEF);
    // Load formatting on 0x80FF7F01
    issue(1'b1, 5'd1, 1'b1, 1'b1, 32'h0, 32'h80FF7F01, 2'd1, 3'b000, 1'b0, 32'h0000007F);
    issue(1'b1, 5'd2, 1'b1, 1'b1, 32'h0, 32'h80FF7F01, 2'd2, 3'b000, 1'b0, 32'hFFFFFFFF);
    issue(1'b1, 5'd3, 1'b1, 1'b1, 32'h0, 32'h80FF7F01, 2'd3, 3'b100, 1'b0, 32'h00000080);
    issue(1'b1, 5'd4, 1'b1, 1'b1, 32'h0, 32'h80FF7F01, 2'd2, 3'b001, 1'b0, 32'hFFFF80FF);
    issue(1'b1, 5'd6, 1'b1, 1'b1, 32'h0, 32'h80FF7F01, 2'd0, 3'b101, 1'b0, 32'h00007F01);
    issue(1'b1, 5'd7, 1'b1, 1'b1, 32'h0, 32'h80FF7F01, 2'd1, 3'b011, 1'b0, 32'h80FF7F01);
    // rd=0 retires without writing
    issue(1'b1, 5'd0, 1'b1, 1'b0, 32'h12345678, 32'h0, 2'd0, 3'd0, 1'b0, 32'h12345678);
    // Back-to-back four, then a three-cycle stall holding the last one
    for (int i = 0; i < 4; i++)
      issue(1'b1, 5'(8 + i), 1'b1, 1'b0, 32'hA000_0000 + 32'(i), 32'h0, 2'd0, 3'd0, 1'b0,
            32'hA000_0000 + 32'(i));
    for (int i = 0; i < 3; i++)
      issue(1'b1, 5'd20, 1'b1, 1'b0, 32'hBAD0_0000, 32'h0, 2'd0, 3'd0, 1'b1, 32'hBAD0_0000);
    repeat (2) idle(1'b0);
    check("instret_after_stall", instret, 64'd12);

    // Random traffic
    for (int i = 0; i < 400; i++) issue_rand();
    for (int i = 0; i < 10; i++) idle(1'b0);
    check("drain", 64'(q.size()), 64'd0);

    // Reset while an entry is held under stall
    mon_en = 1'b0;
    issue(1'b1, 5'd9, 1'b1, 1'b0, 32'h5555AAAA, 32'h0, 2'd0, 3'd0, 1'b0, 32'h5555AAAA);
    idle(1'b1);
    check("held_gpr_wdata", 64'(gpr_wdata), 64'h5555AAAA);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_gpr_wen", 64'(gpr_wen), 64'd0);
    check("midrst_gpr_wdata", 64'(gpr_wdata), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_instret", instret, 64'd0);
    wb_stall = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_retire", 64'(retire), 64'd0);
    check("midrst_instret_w4", 64'(s_instret), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
